// File: rtl/wb_master_pkg.sv
// Shared types for the Wishbone command master: FSM state encoding and response status codes.
package wb_master_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    RETRY,
    RSP
  } state_t;

  localparam logic [1:0] ST_OK    = 2'b00;
  localparam logic [1:0] ST_ERR   = 2'b01;
  localparam logic [1:0] ST_RETRY = 2'b10;
  localparam logic [1:0] ST_TMO   = 2'b11;

endpackage

// File: rtl/wb_master_tmo.sv
// Transaction watchdog: counts enabled cycles since the last clear; expired_o is asserted
// combinationally during the TIMEOUT_CYCLES-th enabled cycle. No backpressure.
module wb_master_tmo #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_cnt <= '0;
    end else if (clr_i) begin
      r_cnt <= '0;
    end else if (en_i && !expired_o) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign expired_o = en_i && (r_cnt == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/wb_cmd_master.sv
// Wishbone pipelined initiator, one outstanding cycle; cmd accept -> stb next cycle, rsp 3 cycles
// later with zero stall/ack-after-1; rsp held until rsp_ready_i. Timeout under WB_MASTER_TIMEOUT_EN.
module wb_cmd_master import wb_master_pkg::*; #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned MAX_RETRY      = 3,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_we_i,
  input  logic [ADDR_WIDTH-1:0] cmd_adr_i,
  input  logic [3:0]            cmd_sel_i,
  input  logic [31:0]           cmd_dat_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [1:0]            rsp_status_o,
  output logic [31:0]           rsp_dat_o,
  output logic                  wb_cyc_o,
  output logic                  wb_stb_o,
  output logic                  wb_we_o,
  output logic [ADDR_WIDTH-1:0] wb_adr_o,
  output logic [3:0]            wb_sel_o,
  output logic [31:0]           wb_dat_o,
  input  logic                  wb_ack_i,
  input  logic                  wb_err_i,
  input  logic                  wb_rty_i,
  input  logic                  wb_stall_i,
  input  logic [31:0]           wb_dat_i,
  output logic                  busy_o
);

  localparam logic [3:0] LP_MAX_RETRY = 4'(MAX_RETRY);

  state_t                r_state, w_state_nxt;
  logic                  r_cyc, r_stb, r_we, r_rsp_vld;
  logic [ADDR_WIDTH-1:0] r_adr;
  logic [3:0]            r_sel, r_retry_cnt;
  logic [31:0]           r_dat, r_rsp_dat;
  logic [1:0]            r_rsp_status;

  logic                  w_cyc_nxt, w_stb_nxt, w_we_nxt, w_rsp_vld_nxt;
  logic [ADDR_WIDTH-1:0] w_adr_nxt;
  logic [3:0]            w_sel_nxt, w_retry_cnt_nxt;
  logic [31:0]           w_dat_nxt, w_rsp_dat_nxt;
  logic [1:0]            w_rsp_status_nxt;

  logic w_cmd_fire, w_term_live, w_err, w_rty, w_ack, w_retry_ok, w_tmo_expired;

  assign cmd_ready_o = (r_state == IDLE) && rst_n_i;
  assign busy_o      = (r_state != IDLE);
  assign w_cmd_fire  = cmd_valid_i && cmd_ready_o;

  // Terminations count only while the request phase is over or being accepted this cycle.
  assign w_term_live = r_cyc && (((r_state == REQ) && !wb_stall_i) || (r_state == WAIT));
  assign w_err       = w_term_live && wb_err_i;
  assign w_rty       = w_term_live && !wb_err_i && wb_rty_i;
  assign w_ack       = w_term_live && !wb_err_i && !wb_rty_i && wb_ack_i;
  assign w_retry_ok  = (r_retry_cnt < LP_MAX_RETRY);

`ifdef WB_MASTER_TIMEOUT_EN
  logic w_tmo_clr, w_tmo_en;
  assign w_tmo_clr = (w_state_nxt == REQ) && (r_state != REQ);
  assign w_tmo_en  = (r_state == REQ) || (r_state == WAIT);

  wb_master_tmo #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_tmo (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .clr_i    (w_tmo_clr),
    .en_i     (w_tmo_en),
    .expired_o(w_tmo_expired)
  );
`else
  assign w_tmo_expired = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:  if (w_cmd_fire) w_state_nxt = REQ;
      REQ, WAIT: begin
        if (w_err || w_ack)          w_state_nxt = RSP;
        else if (w_rty)              w_state_nxt = w_retry_ok ? RETRY : RSP;
        else if (w_tmo_expired)      w_state_nxt = RSP;
        else if ((r_state == REQ) && !wb_stall_i) w_state_nxt = WAIT;
      end
      RETRY: w_state_nxt = REQ;
      RSP:   if (rsp_ready_i) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_cyc_nxt        = r_cyc;
    w_stb_nxt        = r_stb;
    w_we_nxt         = r_we;
    w_adr_nxt        = r_adr;
    w_sel_nxt        = r_sel;
    w_dat_nxt        = r_dat;
    w_rsp_vld_nxt    = r_rsp_vld;
    w_rsp_status_nxt = r_rsp_status;
    w_rsp_dat_nxt    = r_rsp_dat;
    w_retry_cnt_nxt  = r_retry_cnt;
    unique case (r_state)
      IDLE: begin
        if (w_cmd_fire) begin
          w_we_nxt  = cmd_we_i;
          w_adr_nxt = cmd_adr_i;
          w_sel_nxt = cmd_sel_i;
          w_dat_nxt = cmd_dat_i;
          w_cyc_nxt = 1'b1;
          w_stb_nxt = 1'b1;
        end
      end
      REQ, WAIT: begin
        if ((r_state == REQ) && !wb_stall_i) w_stb_nxt = 1'b0;
        if (w_err) begin
          w_cyc_nxt        = 1'b0;
          w_stb_nxt        = 1'b0;
          w_rsp_status_nxt = ST_ERR;
          w_rsp_dat_nxt    = '0;
          w_rsp_vld_nxt    = 1'b1;
        end else if (w_rty) begin
          w_cyc_nxt = 1'b0;
          w_stb_nxt = 1'b0;
          if (w_retry_ok) begin
            w_retry_cnt_nxt = r_retry_cnt + 1'b1;
          end else begin
            w_rsp_status_nxt = ST_RETRY;
            w_rsp_dat_nxt    = '0;
            w_rsp_vld_nxt    = 1'b1;
          end
        end else if (w_ack) begin
          w_cyc_nxt        = 1'b0;
          w_stb_nxt        = 1'b0;
          w_rsp_status_nxt = ST_OK;
          w_rsp_dat_nxt    = r_we ? 32'h0 : wb_dat_i;
          w_rsp_vld_nxt    = 1'b1;
        end else if (w_tmo_expired) begin
          w_cyc_nxt        = 1'b0;
          w_stb_nxt        = 1'b0;
          w_rsp_status_nxt = ST_TMO;
          w_rsp_dat_nxt    = '0;
          w_rsp_vld_nxt    = 1'b1;
        end
      end
      RETRY: begin
        w_cyc_nxt = 1'b1;
        w_stb_nxt = 1'b1;
      end
      RSP: begin
        if (rsp_ready_i) begin
          w_rsp_vld_nxt   = 1'b0;
          w_retry_cnt_nxt = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_cyc        <= 1'b0;
      r_stb        <= 1'b0;
      r_we         <= 1'b0;
      r_adr        <= '0;
      r_sel        <= '0;
      r_dat        <= '0;
      r_rsp_vld    <= 1'b0;
      r_rsp_status <= ST_OK;
      r_rsp_dat    <= '0;
      r_retry_cnt  <= '0;
    end else begin
      r_cyc        <= w_cyc_nxt;
      r_stb        <= w_stb_nxt;
      r_we         <= w_we_nxt;
      r_adr        <= w_adr_nxt;
      r_sel        <= w_sel_nxt;
      r_dat        <= w_dat_nxt;
      r_rsp_vld    <= w_rsp_vld_nxt;
      r_rsp_status <= w_rsp_status_nxt;
      r_rsp_dat    <= w_rsp_dat_nxt;
      r_retry_cnt  <= w_retry_cnt_nxt;
    end
  end

  assign wb_cyc_o     = r_cyc;
  assign wb_stb_o     = r_stb;
  assign wb_we_o      = r_we;
  assign wb_adr_o     = r_adr;
  assign wb_sel_o     = r_sel;
  assign wb_dat_o     = r_dat;
  assign rsp_valid_o  = r_rsp_vld;
  assign rsp_status_o = r_rsp_status;
  assign rsp_dat_o    = r_rsp_dat;

endmodule

// File: tb/tb_wb_cmd_master.sv
// Self-checking bench for wb_cmd_master; expected responses queued at command issue.
module tb_wb_cmd_master;
  import wb_master_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [31:0] cmd_adr, cmd_dat;
  logic [3:0]  cmd_sel;
  logic        rsp_valid, rsp_ready;
  logic [1:0]  rsp_status;
  logic [31:0] rsp_dat;
  logic        wb_cyc, wb_stb, wb_we;
  logic [31:0] wb_adr, wb_dat_o, wb_dat_i;
  logic [3:0]  wb_sel;
  logic        wb_ack, wb_err, wb_rty, wb_stall;
  logic        busy;

  always #5 clk = ~clk;

  wb_cmd_master #(
    .ADDR_WIDTH(32), .MAX_RETRY(3), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
    .cmd_adr_i(cmd_adr), .cmd_sel_i(cmd_sel), .cmd_dat_i(cmd_dat),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_status_o(rsp_status),
    .rsp_dat_o(rsp_dat),
    .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb), .wb_we_o(wb_we), .wb_adr_o(wb_adr),
    .wb_sel_o(wb_sel), .wb_dat_o(wb_dat_o),
    .wb_ack_i(wb_ack), .wb_err_i(wb_err), .wb_rty_i(wb_rty), .wb_stall_i(wb_stall),
    .wb_dat_i(wb_dat_i), .busy_o(busy)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [33:0] exp_q[$];

  // Bus activity monitor, sampled 2ns after each rising edge.
  int   stb_cnt, issue_cnt, gap_cnt;
  logic prev_stb = 1'b0;
  always @(posedge clk) begin
    #2;
    if (wb_stb) stb_cnt++;
    if (wb_stb && !prev_stb) issue_cnt++;
    if (busy && !wb_cyc && !rsp_valid) gap_cnt++;
    prev_stb = wb_stb;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic clr_mon();
    stb_cnt = 0; issue_cnt = 0; gap_cnt = 0;
  endtask

  task automatic expect_rsp(input logic [1:0] st, input logic [31:0] d);
    exp_q.push_back({st, d});
  endtask

  task automatic send_cmd(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                          input logic [31:0] dat);
    int t = 0;
    cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_sel = sel; cmd_dat = dat;
    while (!cmd_ready && t < 50) begin step(); t++; end
    check("cmd_ready", cmd_ready, 1);
    step();
    cmd_valid = 1'b0; cmd_we = ~we; cmd_adr = 32'hFFFF_FFF0; cmd_sel = 4'h0; cmd_dat = 32'h0;
  endtask

  task automatic wait_stb();
    int t = 0;
    while (!wb_stb && t < 50) begin step(); t++; end
    check("stb_seen", wb_stb, 1);
  endtask

  task automatic get_rsp(input int hold);
    int t = 0;
    logic [33:0] e;
    while (!rsp_valid && t < 50) begin step(); t++; end
    check("rsp_valid", rsp_valid, 1);
    if (exp_q.size() == 0) begin
      check("rsp_unexpected", 1, 0);
    end else begin
      e = exp_q.pop_front();
      check("rsp_status", rsp_status, e[33:32]);
      check("rsp_dat", rsp_dat, e[31:0]);
    end
    check("cyc_in_rsp", wb_cyc, 0);
    for (int i = 0; i < hold; i++) begin
      step();
      check("rsp_held", rsp_valid, 1);
      check("cmd_ready_held", cmd_ready, 0);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check("rsp_dropped", rsp_valid, 0);
    check("idle_ready", cmd_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_sel = '0; cmd_dat = '0;
    rsp_ready = 1'b0; wb_ack = 1'b0; wb_err = 1'b0; wb_rty = 1'b0; wb_stall = 1'b0;
    wb_dat_i = '0;
    clr_mon();
    repeat (3) step();
    check("rst_cyc", wb_cyc, 0);
    check("rst_stb", wb_stb, 0);
    check("rst_we", wb_we, 0);
    check("rst_adr", wb_adr, 0);
    check("rst_sel", wb_sel, 0);
    check("rst_dat", wb_dat_o, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_status", rsp_status, 0);
    check("rst_rsp_dat", rsp_dat, 0);
    check("rst_busy", busy, 0);
    check("rst_cmd_ready", cmd_ready, 0);
    rst_n = 1'b1;
    step();
    check("post_rst_ready", cmd_ready, 1);

    // Spurious terminations while idle must be ignored
    wb_ack = 1'b1; wb_err = 1'b1; wb_rty = 1'b1;
    step();
    wb_ack = 1'b0; wb_err = 1'b0; wb_rty = 1'b0;
    step();
    check("spur_busy", busy, 0);
    check("spur_rsp", rsp_valid, 0);

    // T1: write, ack two cycles after stb
    clr_mon();
    expect_rsp(ST_OK, 32'h0);
    send_cmd(1'b1, 32'h4, 4'hF, 32'hDEAD_BEEF);
    check("t1_cyc", wb_cyc, 1);
    check("t1_stb", wb_stb, 1);
    check("t1_we", wb_we, 1);
    check("t1_adr", wb_adr, 32'h4);
    check("t1_sel", wb_sel, 4'hF);
    check("t1_dat", wb_dat_o, 32'hDEAD_BEEF);
    check("t1_busy", busy, 1);
    step();
    check("t1_stb_drop", wb_stb, 0);
    check("t1_cyc_wait", wb_cyc, 1);
    step();
    wb_ack = 1'b1; wb_dat_i = 32'h5555_5555;
    step();
    wb_ack = 1'b0; wb_dat_i = 32'h0;
    get_rsp(0);
    check("t1_stb_cycles", stb_cnt, 1);

    // T2: read with 3 stall cycles; err during stall ignored
    clr_mon();
    expect_rsp(ST_OK, 32'h1234_5678);
    send_cmd(1'b0, 32'h0, 4'hF, 32'h0);
    wb_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("t2_stb_stall", wb_stb, 1);
      check("t2_adr_stable", wb_adr, 32'h0);
      check("t2_we_stable", wb_we, 0);
      check("t2_sel_stable", wb_sel, 4'hF);
      wb_err = (i == 1);
      step();
    end
    wb_err = 1'b0; wb_stall = 1'b0;
    check("t2_stb_last", wb_stb, 1);
    step();
    check("t2_stb_drop", wb_stb, 0);
    check("t2_cyc_wait", wb_cyc, 1);
    wb_ack = 1'b1; wb_dat_i = 32'h1234_5678;
    step();
    wb_ack = 1'b0; wb_dat_i = 32'h0;
    get_rsp(0);
    check("t2_stb_cycles", stb_cnt, 4);

    // T3a: retry exhausted
    clr_mon();
    expect_rsp(ST_RETRY, 32'h0);
    send_cmd(1'b0, 32'h10, 4'hF, 32'h0);
    for (int i = 0; i < 4; i++) begin
      wait_stb();
      check("t3_reissue_adr", wb_adr, 32'h10);
      wb_rty = 1'b1;
      step();
      wb_rty = 1'b0;
    end
    get_rsp(0);
    check("t3_issues", issue_cnt, 4);
    check("t3_gaps", gap_cnt, 3);

    // T3b: two retries then ack
    clr_mon();
    expect_rsp(ST_OK, 32'hA5A5_0001);
    send_cmd(1'b0, 32'h20, 4'hF, 32'h0);
    for (int i = 0; i < 2; i++) begin
      wait_stb();
      wb_rty = 1'b1;
      step();
      wb_rty = 1'b0;
    end
    wait_stb();
    step();
    wb_ack = 1'b1; wb_dat_i = 32'hA5A5_0001;
    step();
    wb_ack = 1'b0; wb_dat_i = 32'h0;
    get_rsp(0);
    check("t3b_issues", issue_cnt, 3);
    check("t3b_gaps", gap_cnt, 2);

    // T4: err and ack together, response held 5 cycles
    expect_rsp(ST_ERR, 32'h0);
    send_cmd(1'b1, 32'h8, 4'h3, 32'h0BAD_F00D);
    step();
    wb_err = 1'b1; wb_ack = 1'b1; wb_dat_i = 32'hFFFF_FFFF;
    step();
    wb_err = 1'b0; wb_ack = 1'b0; wb_dat_i = 32'h0;
    get_rsp(5);

    // T5: no termination
`ifdef WB_MASTER_TIMEOUT_EN
    expect_rsp(ST_TMO, 32'h0);
    send_cmd(1'b1, 32'h30, 4'hF, 32'h1);
    cnt = 0;
    while (wb_cyc && cnt < 50) begin cnt++; step(); end
    check("t5_tmo_cycles", cnt, 8);
    get_rsp(0);
`else
    send_cmd(1'b1, 32'h30, 4'hF, 32'h1);
    repeat (100) step();
    check("t5_cyc_held", wb_cyc, 1);
    check("t5_no_rsp", rsp_valid, 0);
    check("t5_busy", busy, 1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    check("t5_rst_cyc", wb_cyc, 0);
`endif

    // T6: reset while waiting for termination
    send_cmd(1'b0, 32'h40, 4'hF, 32'h0);
    step();
    check("t6_wait_cyc", wb_cyc, 1);
    check("t6_wait_stb", wb_stb, 0);
    rst_n = 1'b0;
    step();
    check("t6_cyc", wb_cyc, 0);
    check("t6_rsp", rsp_valid, 0);
    check("t6_busy", busy, 0);
    check("t6_adr", wb_adr, 0);
    check("t6_ready_in_rst", cmd_ready, 0);
    rst_n = 1'b1;
    step();
    check("t6_ready", cmd_ready, 1);
    wb_ack = 1'b1;
    step();
    wb_ack = 1'b0;
    step();
    check("t6_no_rsp", rsp_valid, 0);

    // T7: minimum latency read
    expect_rsp(ST_OK, 32'hCAFE_F00D);
    send_cmd(1'b0, 32'h44, 4'hF, 32'h0);
    step();
    check("t7_rsp_early", rsp_valid, 0);
    wb_ack = 1'b1; wb_dat_i = 32'hCAFE_F00D;
    step();
    wb_ack = 1'b0; wb_dat_i = 32'h0;
    check("t7_latency", rsp_valid, 1);
    get_rsp(0);

    check("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
